// File: rtl/ising_weight_ctrl.sv
// AXI4-Lite slave for the coupled-cell weight bus: cell write strobes, weight readback, run control.
// Optional anneal down-counter at TIMER is built only when ANNEAL_TIMER_EN is defined.
module ising_weight_ctrl #(
    parameter int unsigned N        = 8,
    parameter int unsigned WEIGHT_W = 4,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic                      clk,
    input  logic                      axi_rst,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [ADDR_W-1:0]         s_awaddr,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    input  logic [31:0]               s_wdata,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    output logic [1:0]                s_bresp,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    input  logic [ADDR_W-1:0]         s_araddr,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [31:0]               s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      cell_wready,
    output logic [N*N-1:0]            cell_addr_match,
    output logic [31:0]               cell_wdata,
    input  logic [N*N*WEIGHT_W-1:0]   cell_rdata,
    output logic                      ising_rstn
);

    localparam int unsigned     Cells      = N * N;
    localparam int unsigned     IdxW       = ADDR_W - 2;
    localparam logic [IdxW-1:0] CtrlIdx    = IdxW'(Cells);
    localparam logic [1:0]      RespOkay   = 2'b00;
    localparam logic [1:0]      RespSlvErr = 2'b10;
`ifdef ANNEAL_TIMER_EN
    localparam logic [IdxW-1:0] TimerIdx   = IdxW'(Cells + 1);
`endif

    typedef enum logic [1:0] {WIdle, WStrobe, WResp} wstate_e;
    typedef enum logic {RIdle, RData} rstate_e;

    wstate_e         w_state;
    rstate_e         r_state;
    logic            aw_held;
    logic            w_held;
    logic [IdxW-1:0] aw_idx_q;
    logic [31:0]     wdata_q;
    logic            wr_err_q;
    logic            run_q;
`ifdef ANNEAL_TIMER_EN
    logic [31:0]     timer_q;
`endif

    logic            aw_hs;
    logic            w_hs;
    logic            wr_fire;
    logic [IdxW-1:0] wr_idx;
    logic [31:0]     wr_data;
    logic            wr_is_cell;
    logic            wr_is_ctrl;
    logic            wr_is_timer;
    logic            wr_cell_ok;
    logic            wr_err;
    logic [Cells-1:0] wr_onehot;
    logic [IdxW-1:0] rd_idx;
    logic [31:0]     rd_val;
    logic            rd_err;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};
    assign ising_rstn       = run_q;
    assign aw_hs            = s_awvalid && s_awready;
    assign w_hs             = s_wvalid && s_wready;
    assign rd_idx           = s_araddr[ADDR_W-1:2];

    // Address/data may arrive in the same cycle as the fire, so bypass the holding registers.
    always_comb begin
        wr_idx     = aw_held ? aw_idx_q : s_awaddr[ADDR_W-1:2];
        wr_data    = w_held ? wdata_q : s_wdata;
        wr_fire    = (w_state == WIdle) && (aw_held || aw_hs) && (w_held || w_hs);
        wr_is_cell = wr_idx < CtrlIdx;
        wr_is_ctrl = wr_idx == CtrlIdx;
`ifdef ANNEAL_TIMER_EN
        wr_is_timer = wr_idx == TimerIdx;
`else
        wr_is_timer = 1'b0;
`endif
        wr_cell_ok = wr_is_cell && !run_q;
        wr_err     = !(wr_cell_ok || wr_is_ctrl || wr_is_timer);
        wr_onehot  = '0;
        for (int unsigned k = 0; k < Cells; k++) begin
            wr_onehot[k] = (wr_idx == IdxW'(k));
        end
    end

    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            w_state         <= WIdle;
            s_awready       <= 1'b0;
            s_wready        <= 1'b0;
            s_bvalid        <= 1'b0;
            s_bresp         <= RespOkay;
            aw_held         <= 1'b0;
            w_held          <= 1'b0;
            aw_idx_q        <= '0;
            wdata_q         <= '0;
            wr_err_q        <= 1'b0;
            cell_wready     <= 1'b0;
            cell_addr_match <= '0;
            cell_wdata      <= '0;
        end else begin
            cell_wready     <= 1'b0;
            cell_addr_match <= '0;
            unique case (w_state)
                WIdle: begin
                    if (wr_fire) begin
                        w_state   <= WStrobe;
                        s_awready <= 1'b0;
                        s_wready  <= 1'b0;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        wr_err_q  <= wr_err;
                        if (wr_cell_ok) begin
                            cell_wready     <= 1'b1;
                            cell_addr_match <= wr_onehot;
                            cell_wdata      <= wr_data;
                        end
                    end else begin
                        if (aw_hs) begin
                            aw_held  <= 1'b1;
                            aw_idx_q <= s_awaddr[ADDR_W-1:2];
                        end
                        if (w_hs) begin
                            w_held  <= 1'b1;
                            wdata_q <= s_wdata;
                        end
                        // Each channel is accepted once; its ready stays low until the response.
                        s_awready <= !(aw_held || aw_hs);
                        s_wready  <= !(w_held || w_hs);
                    end
                end
                WStrobe: begin
                    w_state  <= WResp;
                    s_bvalid <= 1'b1;
                    s_bresp  <= wr_err_q ? RespSlvErr : RespOkay;
                end
                WResp: begin
                    if (s_bready) begin
                        w_state   <= WIdle;
                        s_bvalid  <= 1'b0;
                        s_awready <= 1'b1;
                        s_wready  <= 1'b1;
                    end
                end
                default: w_state <= WIdle;
            endcase
        end
    end

`ifdef ANNEAL_TIMER_EN
    // A register write on the fire edge takes priority over the count, including expiry.
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            run_q   <= 1'b0;
            timer_q <= '0;
        end else if (wr_fire && wr_is_timer) begin
            timer_q <= wr_data;
            run_q   <= (wr_data != 32'd0);
        end else if (wr_fire && wr_is_ctrl) begin
            run_q <= wr_data[0];
            if (!wr_data[0]) begin
                timer_q <= '0;
            end
        end else if (run_q && (timer_q != 32'd0)) begin
            timer_q <= timer_q - 32'd1;
            if (timer_q == 32'd1) begin
                run_q <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            run_q <= 1'b0;
        end else if (wr_fire && wr_is_ctrl) begin
            run_q <= wr_data[0];
        end
    end
`endif

    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        if (rd_idx < CtrlIdx) begin
            for (int unsigned k = 0; k < Cells; k++) begin
                if (rd_idx == IdxW'(k)) begin
                    rd_val[WEIGHT_W-1:0] = cell_rdata[k*WEIGHT_W +: WEIGHT_W];
                end
            end
        end else if (rd_idx == CtrlIdx) begin
            rd_val = {31'b0, run_q};
        end
`ifdef ANNEAL_TIMER_EN
        else if (rd_idx == TimerIdx) begin
            rd_val = timer_q;
        end
`endif
        else begin
            rd_err = 1'b1;
        end
    end

    // Read data is captured at the AR handshake, so a same-cycle cell write returns the old weight.
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            r_state   <= RIdle;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= RespOkay;
        end else begin
            unique case (r_state)
                RIdle: begin
                    if (s_arvalid && s_arready) begin
                        r_state   <= RData;
                        s_arready <= 1'b0;
                        s_rvalid  <= 1'b1;
                        s_rdata   <= rd_val;
                        s_rresp   <= rd_err ? RespSlvErr : RespOkay;
                    end else begin
                        s_arready <= 1'b1;
                    end
                end
                RData: begin
                    if (s_rready) begin
                        r_state   <= RIdle;
                        s_rvalid  <= 1'b0;
                        s_arready <= 1'b1;
                    end
                end
                default: r_state <= RIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ising_weight_ctrl.sv
// Directed bench for ising_weight_ctrl (N = 4): vector table plus multi-cycle handshake sequences.
module tb_ising_weight_ctrl;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int AW = 16;

    logic              clk = 1'b0;
    logic              axi_rst;
    logic              s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [AW-1:0]     s_awaddr, s_araddr;
    logic [31:0]       s_wdata, s_rdata, cell_wdata;
    logic [1:0]        s_bresp, s_rresp;
    logic              s_arvalid, s_arready, s_rvalid, s_rready;
    logic              cell_wready, ising_rstn;
    logic [N*N-1:0]    cell_addr_match;
    logic [N*N*WW-1:0] cell_rdata;

    ising_weight_ctrl #(.N(N), .WEIGHT_W(WW), .ADDR_W(AW)) dut (
        .clk(clk), .axi_rst(axi_rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .cell_wready(cell_wready), .cell_addr_match(cell_addr_match), .cell_wdata(cell_wdata),
        .cell_rdata(cell_rdata), .ising_rstn(ising_rstn)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          strobe_cnt = 0, strobe_cyc = -1, rise_cyc = -1, fall_cyc = -1;
    logic [15:0] strobe_match = '0;
    logic [31:0] strobe_data = '0;
    logic        prev_rstn = 1'b0;
    int          errors = 0, checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cell_wready) begin
            strobe_cnt   <= strobe_cnt + 1;
            strobe_cyc   <= cyc;
            strobe_match <= cell_addr_match;
            strobe_data  <= cell_wdata;
        end
        if (ising_rstn && !prev_rstn) rise_cyc <= cyc;
        if (!ising_rstn && prev_rstn) fall_cyc <= cyc;
        prev_rstn <= ising_rstn;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [31:0] data,
                            output logic [1:0] resp, output int hs_cyc, output int bv_cyc);
        bit   aw_d, w_d;
        logic a, w;
        aw_d = 0; w_d = 0; bv_cyc = -1; resp = 2'b11;
        s_awaddr = addr; s_wdata = data; s_awvalid = 1; s_wvalid = 1; s_bready = 1;
        for (int n = 0; n < 20 && !(aw_d && w_d); n++) begin
            a = s_awvalid && s_awready;
            w = s_wvalid && s_wready;
            tick();
            if (a) begin aw_d = 1; s_awvalid = 0; end
            if (w) begin w_d = 1; s_wvalid = 0; end
        end
        s_awvalid = 0; s_wvalid = 0;
        chk("wr_handshake", {31'b0, aw_d && w_d}, 32'd1);
        hs_cyc = cyc;
        for (int n = 0; n < 20; n++) begin
            if (s_bvalid) begin
                bv_cyc = cyc; resp = s_bresp;
                tick();
                break;
            end
            tick();
        end
        s_bready = 0;
    endtask

    task automatic do_read(input logic [15:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int ar_cyc);
        bit got, rv;
        got = 0; rv = 0; data = 'x; resp = 2'b11;
        s_araddr = addr; s_arvalid = 1; s_rready = 1;
        for (int n = 0; n < 20; n++) begin
            if (s_arready) begin tick(); got = 1; break; end
            tick();
        end
        s_arvalid = 0;
        ar_cyc = cyc;
        for (int n = 0; n < 20; n++) begin
            if (s_rvalid) begin
                data = s_rdata; resp = s_rresp; rv = 1;
                tick();
                break;
            end
            tick();
        end
        s_rready = 0;
        chk("rd_handshake", {31'b0, got && rv}, 32'd1);
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          strobe;
        logic [15:0] match;
        logic [31:0] cwdata;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          hs, bv, ar, s0;
        bit          ok;

        // wr, addr, data, resp, rdata, strobe, match, cell_wdata afterwards
        vecs[0]  = '{1'b1, 16'h0014, 32'd3,        2'b00, 32'h0, 1'b1, 16'h0020, 32'd3};
        vecs[1]  = '{1'b1, 16'h003C, 32'hDEADBEEF, 2'b00, 32'h0, 1'b1, 16'h8000, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 16'h0003, 32'h12,       2'b00, 32'h0, 1'b1, 16'h0001, 32'h12};
        vecs[3]  = '{1'b1, 16'h004C, 32'd1,        2'b10, 32'h0, 1'b0, 16'h0000, 32'h12};
        vecs[4]  = '{1'b1, 16'h0040, 32'hFFFFFFFE, 2'b00, 32'h0, 1'b0, 16'h0000, 32'h12};
        vecs[5]  = '{1'b1, 16'h0080, 32'd1,        2'b10, 32'h0, 1'b0, 16'h0000, 32'h12};
        vecs[6]  = '{1'b0, 16'h001C, 32'h0,        2'b00, 32'hA, 1'b0, 16'h0000, 32'h0};
        vecs[7]  = '{1'b0, 16'h0000, 32'h0,        2'b00, 32'hD, 1'b0, 16'h0000, 32'h0};
        vecs[8]  = '{1'b0, 16'h003E, 32'h0,        2'b00, 32'h2, 1'b0, 16'h0000, 32'h0};
        vecs[9]  = '{1'b0, 16'h0048, 32'h0,        2'b10, 32'h0, 1'b0, 16'h0000, 32'h0};
        vecs[10] = '{1'b0, 16'h0040, 32'h0,        2'b00, 32'h0, 1'b0, 16'h0000, 32'h0};
        vecs[11] = '{1'b0, 16'hFFFC, 32'h0,        2'b10, 32'h0, 1'b0, 16'h0000, 32'h0};

        for (int k = 0; k < N * N; k++) cell_rdata[k*WW +: WW] = 4'(k ^ 13);
        axi_rst = 1; s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", {31'b0, s_awready}, 0);
        chk("rst_wready", {31'b0, s_wready}, 0);
        chk("rst_arready", {31'b0, s_arready}, 0);
        chk("rst_bvalid", {31'b0, s_bvalid}, 0);
        chk("rst_rvalid", {31'b0, s_rvalid}, 0);
        chk("rst_resp", {28'b0, s_bresp, s_rresp}, 0);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_cell_wready", {31'b0, cell_wready}, 0);
        chk("rst_cell_match", {16'b0, cell_addr_match}, 0);
        chk("rst_cell_wdata", cell_wdata, 0);
        chk("rst_ising_rstn", {31'b0, ising_rstn}, 0);
        axi_rst = 0;
        tick();
        chk("post_rst_ready", {29'b0, s_awready, s_wready, s_arready}, 32'h7);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                s0 = strobe_cnt;
                do_write(vecs[i].addr, vecs[i].data, resp, hs, bv);
                chk($sformatf("v%0d_bresp", i), {30'b0, resp}, {30'b0, vecs[i].resp});
                chk($sformatf("v%0d_strobes", i), strobe_cnt - s0, {31'b0, vecs[i].strobe});
                chk($sformatf("v%0d_blat", i), bv - hs, 1);
                chk($sformatf("v%0d_cell_wdata", i), cell_wdata, vecs[i].cwdata);
                if (vecs[i].strobe) begin
                    chk($sformatf("v%0d_match", i), {16'b0, strobe_match}, {16'b0, vecs[i].match});
                    chk($sformatf("v%0d_sdata", i), strobe_data, vecs[i].data);
                    chk($sformatf("v%0d_slat", i), strobe_cyc - hs, 0);
                end
            end else begin
                do_read(vecs[i].addr, rdata, resp, ar);
                chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
                chk($sformatf("v%0d_rresp", i), {30'b0, resp}, {30'b0, vecs[i].resp});
            end
        end

        // AW leads W by three cycles; bready held low for five.
        s0 = strobe_cnt; ok = 0;
        s_awaddr = 16'h0008; s_awvalid = 1; s_bready = 0;
        for (int n = 0; n < 20; n++) begin
            if (s_awready) begin tick(); ok = 1; break; end
            tick();
        end
        s_awvalid = 0;
        chk("t2_aw_hs", {31'b0, ok}, 1);
        for (int n = 0; n < 2; n++) begin
            chk("t2_awready_low", {31'b0, s_awready}, 0);
            chk("t2_no_early_strobe", strobe_cnt - s0, 0);
            tick();
        end
        s_wdata = 32'h77; s_wvalid = 1; ok = 0;
        for (int n = 0; n < 20; n++) begin
            if (s_wready) begin tick(); ok = 1; break; end
            tick();
        end
        s_wvalid = 0;
        hs = cyc;
        chk("t2_w_hs", {31'b0, ok}, 1);
        tick();
        for (int n = 0; n < 5; n++) begin
            chk("t2_bvalid_held", {31'b0, s_bvalid}, 1);
            tick();
        end
        chk("t2_bresp", {30'b0, s_bresp}, 0);
        s_bready = 1;
        tick();
        s_bready = 0;
        chk("t2_bvalid_done", {31'b0, s_bvalid}, 0);
        chk("t2_strobes", strobe_cnt - s0, 1);
        chk("t2_slat", strobe_cyc - hs, 0);
        chk("t2_match", {16'b0, strobe_match}, 32'h0004);
        chk("t2_sdata", strobe_data, 32'h77);

        // Read with rready low: data must stay put even if the cell weight moves.
        s_araddr = 16'h001C; s_arvalid = 1; s_rready = 0; ok = 0;
        for (int n = 0; n < 20; n++) begin
            if (s_arready) begin tick(); ok = 1; break; end
            tick();
        end
        s_arvalid = 0;
        chk("t3_ar_hs", {31'b0, ok}, 1);
        for (int n = 0; n < 4; n++) begin
            chk("t3_rvalid_held", {31'b0, s_rvalid}, 1);
            chk("t3_rdata_held", s_rdata, 32'hA);
            if (n == 1) cell_rdata[7*WW +: WW] = 4'h5;
            tick();
        end
        chk("t3_rresp", {30'b0, s_rresp}, 0);
        s_rready = 1;
        tick();
        s_rready = 0;
        chk("t3_rvalid_done", {31'b0, s_rvalid}, 0);
        cell_rdata[7*WW +: WW] = 4'hA;

        // Run blocks weight writes.
        do_write(16'h0040, 32'd1, resp, hs, bv);
        chk("t4_ctrl_bresp", {30'b0, resp}, 0);
        chk("t4_rstn_high", {31'b0, ising_rstn}, 1);
        s0 = strobe_cnt;
        do_write(16'h0000, 32'd5, resp, hs, bv);
        chk("t4_run_bresp", {30'b0, resp}, 32'h2);
        chk("t4_run_strobes", strobe_cnt - s0, 0);
        chk("t4_cell_wdata_held", cell_wdata, 32'h77);
        do_read(16'h0048, rdata, resp, ar);
        chk("t4_oor_rdata", rdata, 0);
        chk("t4_oor_rresp", {30'b0, resp}, 32'h2);
        do_read(16'h0040, rdata, resp, ar);
        chk("t4_ctrl_rdata", rdata, 1);
        do_write(16'h0040, 32'd0, resp, hs, bv);
        chk("t4_rstn_low", {31'b0, ising_rstn}, 0);

`ifdef ANNEAL_TIMER_EN
        do_write(16'h0044, 32'd10, resp, hs, bv);
        chk("t5_bresp", {30'b0, resp}, 0);
        chk("t5_rise", rise_cyc - hs, 0);
        do_read(16'h0044, rdata, resp, ar);
        chk("t5_remaining", rdata, 32'(11 - (ar - hs)));
        chk("t5_rresp", {30'b0, resp}, 0);
        for (int n = 0; n < 30; n++) begin
            if (fall_cyc > hs) break;
            tick();
        end
        chk("t5_fall", fall_cyc - hs, 10);
        do_read(16'h0044, rdata, resp, ar);
        chk("t5_expired", rdata, 0);
`else
        do_write(16'h0044, 32'd10, resp, hs, bv);
        chk("t5_timer_wr_slverr", {30'b0, resp}, 32'h2);
        chk("t5_timer_no_run", {31'b0, ising_rstn}, 0);
        do_read(16'h0044, rdata, resp, ar);
        chk("t5_timer_rd_slverr", {30'b0, resp}, 32'h2);
`endif

        // Reset while the write response is pending.
        do_write(16'h0040, 32'd1, resp, hs, bv);
        s_awaddr = 16'h0040; s_wdata = 32'd1; s_awvalid = 1; s_wvalid = 1; s_bready = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (s_bvalid) break;
        end
        s_awvalid = 0; s_wvalid = 0;
        chk("t6_in_wresp", {31'b0, s_bvalid}, 1);
        #2 axi_rst = 1;
        #1;
        chk("t6_bvalid_async", {31'b0, s_bvalid}, 0);
        chk("t6_rstn_async", {31'b0, ising_rstn}, 0);
        s0 = strobe_cnt;
        tick();
        axi_rst = 0;
        repeat (4) tick();
        chk("t6_no_strobe", strobe_cnt - s0, 0);
        chk("t6_no_bvalid", {31'b0, s_bvalid}, 0);
        chk("t6_ready_back", {30'b0, s_awready, s_wready}, 32'h3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
